// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: modes, opcodes,
// exe commands, condition codes and ex_ctrl bit positions.
package id_stage_pipe_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    localparam int CTRL_W      = 9;
    localparam int CTRL_WB     = 8;
    localparam int CTRL_MR     = 7;
    localparam int CTRL_MW     = 6;
    localparam int CTRL_CMD_HI = 5;
    localparam int CTRL_CMD_LO = 2;
    localparam int CTRL_B      = 1;
    localparam int CTRL_S      = 0;

    // sr is packed {N,Z,C,V}
    function automatic logic cond_pass(
        input logic [3:0] c,
        input logic [3:0] sr
    );
        logic n, z, cf, v;
        {n, z, cf, v} = sr;
        case (c)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return cf;
            COND_CC: return ~cf;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return cf & ~z;
            COND_LS: return ~cf | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Register file: NREG x DATA_W, two combinational read ports
// with write-first bypass, one synchronous write port.
module id_regfile
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        raddr1_i,
    input  logic [3:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_i && waddr_i == 4'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    // Out-of-range indices match no entry and read as zero.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr1_i == 4'(i)) begin
                rdata1_o = (we_i && waddr_i == raddr1_i)
                         ? wdata_i : mem_q[i];
            end
            if (raddr2_i == 4'(i)) begin
                rdata2_o = (we_i && waddr_i == raddr2_i)
                         ? wdata_i : mem_q[i];
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decode, condition check, hazard
// stall, register read and the ID/EXE pipeline register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int FWD    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc_in,
    input  logic [3:0]        sr,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic [3:0]        exe_dest,
    input  logic              exe_mem_r_en,
    input  logic              mem_wb_en,
    input  logic [3:0]        mem_dest,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [8:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [25:0]       ex_instr,
    output logic [3:0]        ex_dest,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2,
    output logic [31:0]       ex_pc
);

    localparam bit FWD_ON = (FWD != 0);

    logic [1:0] mode;
    logic [3:0] op;
    logic       s_bit;
    logic       imm;
    logic       is_str;
    logic       is_b;
    logic       mov_mvn;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
    logic       hazard;
    logic       go;

    logic [CTRL_W-1:0] ctrl_dec;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] rm_val;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rn_q, rm_q;
    logic [25:0]       instr_q;
    logic [3:0]        dest_q, src1_q, src2_q;
    logic [31:0]       pc_q;

    assign mode    = instr[27:26];
    assign imm     = instr[25];
    assign op      = instr[24:21];
    assign s_bit   = instr[20];
    assign is_str  = (mode == MODE_MEM) && !s_bit;
    assign is_b    = (mode == MODE_BR);
    assign mov_mvn = (mode == MODE_DP)
                  && (op == OP_MOV || op == OP_MVN);

    assign src1 = instr[19:16];
    assign src2 = is_str ? instr[15:12] : instr[3:0];
    assign use1 = !(is_b || mov_mvn);
    assign use2 = !imm || is_str;

    always_comb begin
        logic     wb, mr, mw, b, s;
        exe_cmd_e cmd;
        wb  = 1'b0;
        mr  = 1'b0;
        mw  = 1'b0;
        b   = 1'b0;
        s   = 1'b0;
        cmd = CMD_NOP;
        unique case (mode)
            MODE_DP: begin
                s  = s_bit;
                wb = 1'b1;
                unique case (op)
                    OP_MOV: cmd = CMD_MOV;
                    OP_MVN: cmd = CMD_MVN;
                    OP_ADD: cmd = CMD_ADD;
                    OP_ADC: cmd = CMD_ADC;
                    OP_SUB: cmd = CMD_SUB;
                    OP_SBC: cmd = CMD_SBC;
                    OP_AND: cmd = CMD_AND;
                    OP_ORR: cmd = CMD_ORR;
                    OP_EOR: cmd = CMD_EOR;
                    OP_CMP: begin cmd = CMD_SUB; wb = 1'b0; end
                    OP_TST: begin cmd = CMD_AND; wb = 1'b0; end
                    default: begin wb = 1'b0; s = 1'b0; end
                endcase
            end
            MODE_MEM: begin
                cmd = CMD_ADD;
                wb  = s_bit;
                mr  = s_bit;
                mw  = !s_bit;
            end
            MODE_BR: b = 1'b1;
            default: ;
        endcase
        ctrl_dec = '0;
        ctrl_dec[CTRL_WB] = wb;
        ctrl_dec[CTRL_MR] = mr;
        ctrl_dec[CTRL_MW] = mw;
        ctrl_dec[CTRL_CMD_HI:CTRL_CMD_LO] = cmd;
        ctrl_dec[CTRL_B] = b;
        ctrl_dec[CTRL_S] = s;
    end

    // With forwarding only a load in EXE cannot be bypassed.
    function automatic logic busy(input logic [3:0] r);
        if (FWD_ON) begin
            return exe_mem_r_en && exe_dest == r;
        end
        return (exe_wb_en && exe_dest == r)
            || (mem_wb_en && mem_dest == r);
    endfunction

    assign hazard = (use1 && busy(src1)) || (use2 && busy(src2));
    assign stall  = if_valid && hazard && !flush;
    assign go     = if_valid && cond_pass(instr[31:28], sr);

    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (!(flush || stall)) begin
            valid_d = go;
            ctrl_d  = go ? ctrl_dec : '0;
        end
    end

    id_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_en),
        .waddr_i  (wb_dest),
        .wdata_i  (wb_value),
        .raddr1_i (src1),
        .raddr2_i (src2),
        .rdata1_o (rn_val),
        .rdata2_o (rm_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            instr_q <= '0;
            dest_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            if (!(flush || stall)) begin
                rn_q    <= rn_val;
                rm_q    <= rm_val;
                instr_q <= instr[25:0];
                dest_q  <= instr[15:12];
                src1_q  <= src1;
                src2_q  <= src2;
                pc_q    <= pc_in;
            end
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_val_rn = rn_q;
    assign ex_val_rm = rm_q;
    assign ex_instr  = instr_q;
    assign ex_dest   = dest_q;
    assign ex_src1   = src1_q;
    assign ex_src2   = src2_q;
    assign ex_pc     = pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed cases plus random traffic
// against a table-driven model, on FWD=1 and FWD=0 instances.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instr, pc_in;
    logic [3:0]  sr;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        exe_wb_en, exe_mem_r_en, mem_wb_en, flush;
    logic [3:0]  exe_dest, mem_dest;

    logic        stall  [2];
    logic        valid  [2];
    logic [8:0]  ctrl   [2];
    logic [31:0] rn     [2];
    logic [31:0] rm     [2];
    logic [25:0] ins    [2];
    logic [3:0]  dest   [2];
    logic [3:0]  s1     [2];
    logic [3:0]  s2     [2];
    logic [31:0] pc     [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_stage_pipe #(.DATA_W(32), .NREG(16), .FWD(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .if_valid     (if_valid),
            .instr        (instr),
            .pc_in        (pc_in),
            .sr           (sr),
            .wb_en        (wb_en),
            .wb_dest      (wb_dest),
            .wb_value     (wb_value),
            .exe_wb_en    (exe_wb_en),
            .exe_dest     (exe_dest),
            .exe_mem_r_en (exe_mem_r_en),
            .mem_wb_en    (mem_wb_en),
            .mem_dest     (mem_dest),
            .flush        (flush),
            .stall        (stall[g]),
            .ex_valid     (valid[g]),
            .ex_ctrl      (ctrl[g]),
            .ex_val_rn    (rn[g]),
            .ex_val_rm    (rm[g]),
            .ex_instr     (ins[g]),
            .ex_dest      (dest[g]),
            .ex_src1      (s1[g]),
            .ex_src2      (s2[g]),
            .ex_pc        (pc[g])
        );
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [8:0]  ctrl;
        logic [31:0] rn, rm, pc;
        logic [25:0] ins;
        logic [3:0]  dest, s1, s2;
    } ex_t;

    ex_t         m [2];
    logic [31:0] rf [16];

    // {wb, mem_r, mem_w, cmd, b, s} straight from the opcode table
    function automatic logic [8:0] m_dec(input logic [31:0] i);
        logic [3:0] op;
        logic       s;
        op = i[24:21];
        s  = i[20];
        case (i[27:26])
            2'b00: case (op)
                4'hD: return {3'b100, 4'd1, 1'b0, s};
                4'hF: return {3'b100, 4'd9, 1'b0, s};
                4'h4: return {3'b100, 4'd2, 1'b0, s};
                4'h5: return {3'b100, 4'd3, 1'b0, s};
                4'h2: return {3'b100, 4'd4, 1'b0, s};
                4'h6: return {3'b100, 4'd5, 1'b0, s};
                4'h0: return {3'b100, 4'd6, 1'b0, s};
                4'hC: return {3'b100, 4'd7, 1'b0, s};
                4'h1: return {3'b100, 4'd8, 1'b0, s};
                4'hA: return {3'b000, 4'd4, 1'b0, s};
                4'h8: return {3'b000, 4'd6, 1'b0, s};
                default: return 9'd0;
            endcase
            2'b01: return s ? 9'b110_0010_00 : 9'b001_0010_00;
            2'b10: return 9'b000_0000_10;
            default: return 9'd0;
        endcase
    endfunction

    function automatic bit m_cond(input logic [3:0] c,
                                  input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0: return z;        1: return !z;
            2: return cf;       3: return !cf;
            4: return n;        5: return !n;
            6: return v;        7: return !v;
            8: return cf && !z; 9: return !cf || z;
            10: return n == v;  11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_str(input logic [31:0] i);
        return i[27:26] == 2'b01 && !i[20];
    endfunction

    function automatic logic [3:0] m_src2(input logic [31:0] i);
        return is_str(i) ? i[15:12] : i[3:0];
    endfunction

    function automatic bit busy(input bit fwd, input logic [3:0] r);
        if (fwd) return exe_mem_r_en && exe_dest == r;
        return (exe_wb_en && exe_dest == r)
            || (mem_wb_en && mem_dest == r);
    endfunction

    function automatic bit m_hazard(input bit fwd,
                                    input logic [31:0] i);
        bit u1, u2;
        u1 = !(i[27:26] == 2'b10 || (i[27:26] == 2'b00
             && (i[24:21] == 4'hD || i[24:21] == 4'hF)));
        u2 = !i[25] || is_str(i);
        return (u1 && busy(fwd, i[19:16]))
            || (u2 && busy(fwd, m_src2(i)));
    endfunction

    function automatic logic [31:0] rd(input logic [3:0] r);
        return (wb_en && wb_dest == r) ? wb_value : rf[r];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) m[k] <= '0;
            for (int r = 0; r < 16; r++) rf[r] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush || (if_valid && m_hazard(k == 1, instr))) begin
                    m[k].v    <= 1'b0;
                    m[k].ctrl <= '0;
                end else begin
                    m[k].v    <= if_valid && m_cond(instr[31:28], sr);
                    m[k].ctrl <= (if_valid && m_cond(instr[31:28], sr))
                               ? m_dec(instr) : 9'd0;
                    m[k].rn   <= rd(instr[19:16]);
                    m[k].rm   <= rd(m_src2(instr));
                    m[k].pc   <= pc_in;
                    m[k].ins  <= instr[25:0];
                    m[k].dest <= instr[15:12];
                    m[k].s1   <= instr[19:16];
                    m[k].s2   <= m_src2(instr);
                end
            end
            if (wb_en) rf[wb_dest] <= wb_value;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.stall", k), 32'(stall[k]),
                  32'(if_valid && !flush && m_hazard(k == 1, instr)));
            check($sformatf("u%0d.valid", k), 32'(valid[k]), 32'(m[k].v));
            check($sformatf("u%0d.ctrl", k), 32'(ctrl[k]), 32'(m[k].ctrl));
            check($sformatf("u%0d.rn", k), rn[k], m[k].rn);
            check($sformatf("u%0d.rm", k), rm[k], m[k].rm);
            check($sformatf("u%0d.instr", k), 32'(ins[k]), 32'(m[k].ins));
            check($sformatf("u%0d.dest", k), 32'(dest[k]), 32'(m[k].dest));
            check($sformatf("u%0d.src1", k), 32'(s1[k]), 32'(m[k].s1));
            check($sformatf("u%0d.src2", k), 32'(s2[k]), 32'(m[k].s2));
            check($sformatf("u%0d.pc", k), pc[k], m[k].pc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wb_en = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_wb_en = 0; flush = 0;
        exe_dest = 0; mem_dest = 0;
    endtask

    initial begin
        rst = 1; if_valid = 0; instr = 0; pc_in = 0; sr = 0;
        wb_dest = 0; wb_value = 0;
        quiet();

        check("pin.dec_add", 32'(m_dec(32'hE0821003)), 32'h108);
        check("pin.dec_ldr", 32'(m_dec(32'hE5921000)), 32'h188);
        check("pin.cond_gt", 32'(m_cond(4'hC, 4'b0000)), 32'd1);
        check("pin.cond_lt", 32'(m_cond(4'hB, 4'b1000)), 32'd1);

        repeat (2) cyc();
        check("rst.valid", 32'(valid[1]), 0);
        check("rst.ctrl", 32'(ctrl[1]), 0);
        check("rst.pc", pc[1], 0);
        rst = 0;

        wb_en = 1; wb_dest = 2; wb_value = 5; cyc();
        wb_dest = 3; wb_value = 7; cyc();
        wb_en = 0;
        instr = 32'hE0821003; pc_in = 32'h104; if_valid = 1;
        cyc();
        check("add.valid", 32'(valid[1]), 1);
        check("add.ctrl", 32'(ctrl[1]), 32'h108);
        check("add.rn", rn[1], 5);
        check("add.rm", rm[1], 7);
        check("add.dest", 32'(dest[1]), 1);
        check("add.pc", pc[1], 32'h104);

        wb_en = 1; wb_dest = 2; wb_value = 9; cyc();
        wb_en = 0;
        check("bypass.rn", rn[1], 9);

        exe_wb_en = 1; exe_dest = 2; #1;
        check("raw.stall_fwd0", 32'(stall[0]), 1);
        check("raw.stall_fwd1", 32'(stall[1]), 0);
        cyc();
        check("raw.valid_fwd0", 32'(valid[0]), 0);
        check("raw.valid_fwd1", 32'(valid[1]), 1);
        quiet();

        instr = 32'h00821003; sr = 4'b0000; cyc();
        check("eq_fail.valid", 32'(valid[1]), 0);
        check("eq_fail.ctrl", 32'(ctrl[1]), 0);
        sr = 4'b0100; cyc();
        check("eq_pass.valid", 32'(valid[1]), 1);

        instr = 32'hE0821003; exe_mem_r_en = 1; exe_dest = 2; #1;
        check("lu.stall", 32'(stall[1]), 1);
        flush = 1; #1;
        check("flush.stall1", 32'(stall[1]), 0);
        check("flush.stall0", 32'(stall[0]), 0);
        cyc();
        check("flush.valid1", 32'(valid[1]), 0);
        check("flush.valid0", 32'(valid[0]), 0);
        quiet();

        for (int t = 0; t < 1500; t++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[31:28] = 4'hE;
            r[19:16] = 4'($urandom_range(0, 4));
            r[15:12] = 4'($urandom_range(0, 4));
            r[3:0]   = 4'($urandom_range(0, 4));
            instr        = r;
            pc_in        = $urandom;
            sr           = 4'($urandom);
            if_valid     = $urandom_range(0, 4) != 0;
            wb_en        = $urandom_range(0, 1) != 0;
            wb_dest      = 4'($urandom);
            wb_value     = $urandom;
            exe_wb_en    = $urandom_range(0, 1) != 0;
            exe_mem_r_en = $urandom_range(0, 2) == 0;
            exe_dest     = 4'($urandom_range(0, 4));
            mem_wb_en    = $urandom_range(0, 1) != 0;
            mem_dest     = 4'($urandom_range(0, 4));
            flush        = $urandom_range(0, 9) == 0;
            cyc();
        end

        rst = 1; #1;
        check("mid_rst.valid", 32'(valid[1]), 0);
        check("mid_rst.ctrl", 32'(ctrl[1]), 0);
        check("mid_rst.rn", rn[1], 0);
        check("mid_rst.pc", pc[1], 0);
        check("mid_rst.valid0", 32'(valid[0]), 0);
        cyc();
        rst = 0;
        quiet();
        instr = 32'hE0821003; if_valid = 1; sr = 0;
        cyc();
        check("post_rst.valid", 32'(valid[1]), 1);
        check("post_rst.r2", rn[1], 0);
        check("post_rst.r3", rm[1], 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
